// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state types and op classification helpers for the HILO unit
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MFHI  = 4'd1,
    OP_MFLO  = 4'd2,
    OP_MTHI  = 4'd3,
    OP_MTLO  = 4'd4,
    OP_MULT  = 4'd5,
    OP_MULTU = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10,
    OP_DIV   = 4'd11,
    OP_DIVU  = 4'd12
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

  // Undefined encodings are treated like NONE so they can never stall the pipe.
  function automatic logic is_hilo_access(muldiv_op_t op);
    return (op != OP_NONE) && (op <= OP_DIVU);
  endfunction

  function automatic logic is_mul_op(muldiv_op_t op);
    return (op >= OP_MULT) && (op <= OP_MSUBU);
  endfunction

  function automatic logic is_div_op(muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - restoring unsigned divider core, one quotient bit per cycle
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             running;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Trial subtraction of the divisor from the partial remainder with the next dividend bit shifted in.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, div_q};
  end

  // done is high in the cycle whose closing edge performs the final iteration.
  assign done      = running && (count == CW'(WIDTH - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Load operands on start, then retire one quotient bit per edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      running <= 1'b0;
      count   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      quo_q   <= dividend;
      rem_q   <= '0;
      div_q   <= divisor;
    end else if (running) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      count <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle multiply/divide unit owning the HI/LO pair with stall interlock
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             commit,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  muldiv_state_t      state;
  logic [CW-1:0]      mul_cnt;
  muldiv_op_t         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] hilo;

  logic               accept;
  muldiv_op_t         m_op;
  logic [WIDTH-1:0]   m_a;
  logic [WIDTH-1:0]   m_b;
  logic               m_sgn;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_result;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               div_start;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH-1:0]   fix_q;
  logic [WIDTH-1:0]   fix_r;

  assign hi     = hilo[2*WIDTH-1:WIDTH];
  assign lo     = hilo[WIDTH-1:0];
  assign busy   = (state != ST_IDLE);
  assign stall  = op_valid && is_hilo_access(op) && busy;
  assign accept = op_valid && commit && !busy && is_hilo_access(op);

  // Move-from reads are combinational so a released stall sees the freshly written HILO.
  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI) rd_data = hi;
    else if (op == OP_MFLO) rd_data = lo;
  end

  // Multiplier takes live operands when writing at the accept edge, captured ones otherwise.
  always_comb begin
    m_op    = (state == ST_IDLE) ? op : op_q;
    m_a     = (state == ST_IDLE) ? a : a_q;
    m_b     = (state == ST_IDLE) ? b : b_q;
    m_sgn   = is_signed_op(m_op);
    ext_a   = {{WIDTH{m_sgn & m_a[WIDTH-1]}}, m_a};
    ext_b   = {{WIDTH{m_sgn & m_b[WIDTH-1]}}, m_b};
    product = ext_a * ext_b;
    case (m_op)
      OP_MADD, OP_MADDU: mul_result = hilo + product;
      OP_MSUB, OP_MSUBU: mul_result = hilo - product;
      default:           mul_result = product;
    endcase
  end

  // Divider runs on magnitudes; signs are restored from the captured operands in FIX.
  always_comb begin
    a_neg     = is_signed_op(op) & a[WIDTH-1];
    b_neg     = is_signed_op(op) & b[WIDTH-1];
    mag_a     = a_neg ? (~a + 1'b1) : a;
    mag_b     = b_neg ? (~b + 1'b1) : b;
    div_start = accept && is_div_op(op);
    q_neg     = (op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg     = (op_q == OP_DIV) && a_q[WIDTH-1];
    if (b_q == '0) begin
      fix_q = '1;
      fix_r = a_q;
    end else begin
      fix_q = q_neg ? (~div_quo + 1'b1) : div_quo;
      fix_r = r_neg ? (~div_rem + 1'b1) : div_rem;
    end
  end

  div_iter #(
    .WIDTH(WIDTH)
  ) u_div_iter (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // Control FSM and HILO register; in-flight work only stops on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      mul_cnt <= '0;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hilo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            if (op == OP_MTHI) begin
              hilo[2*WIDTH-1:WIDTH] <= a;
            end else if (op == OP_MTLO) begin
              hilo[WIDTH-1:0] <= b;
            end else if (is_mul_op(op)) begin
              if (MUL_LATENCY == 0) begin
                hilo <= mul_result;
              end else begin
                state   <= ST_MUL;
                mul_cnt <= CW'(MUL_LATENCY - 1);
              end
            end else if (is_div_op(op)) begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (mul_cnt == '0) begin
            hilo  <= mul_result;
            state <= ST_IDLE;
          end else begin
            mul_cnt <= mul_cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (div_done) state <= ST_FIX;
        end
        ST_FIX: begin
          hilo  <= {fix_r, fix_q};
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS32 execute stage. It is the next generation of the execute-stage HILO logic, with these additions:
- configurable operand width;
- configurable pipelined multiplier latency;
- an iterative signed/unsigned divider with defined divide-by-zero and overflow results;
- an explicit busy/stall interlock covering both multiply and divide.

Instructions that do not touch HI/LO are never stalled.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_LATENCY, 2, cycles from accept to HILO write for multiply-class ops; 0 means the write happens at the accept edge.

Ports:
- Clock and reset: clock, reset; reset is synchronous, active-high.
- Handshake and operands:
  - op_valid  in  1  An EX-stage instruction is present.
  - op  in  4  muldiv_op_t encoding.
  - a  in  WIDTH  rs operand.
  - b  in  WIDTH  rt operand.
  - commit  in  1  Equals ~(EX_Stall | EX_Flush); an op takes effect only when commit is high.
- Results and status:
  - rd_data  out  WIDTH  Current HI for MFHI, current LO for MFLO, otherwise 0.
  - stall  out  1  Present op accesses HILO while the unit is busy.
  - busy  out  1  A multiply or divide is in flight.
  - hi  out  WIDTH  HILO[2W-1:W], for debug.
  - lo  out  WIDTH  HILO[W-1:0], for debug.

## Operation
Ops:
- NONE, MFHI, MFLO, MTHI, MTLO.
- MULT, MULTU, MADD, MADDU, MSUB, MSUBU.
- DIV, DIVU.

Every op except NONE is a HILO access.

Accept rule:
- Accept = op_valid & commit & ~busy & (op is a HILO access).
- When busy is high and the present op is a HILO access, stall is asserted and nothing is accepted.

Single-cycle ops:
- MTHI writes HI←a at the accept edge.
- MTLO writes LO←b at the accept edge.
- MFHI/MFLO drive rd_data combinationally; no state change.

Multiply-class ops:
- The 2W-bit product of a and b is signed for MULT/MADD/MSUB and unsigned for the U variants.
- MULT/MULTU: HILO←product.
- MADD/MADDU: HILO←HILO+product.
- MSUB/MSUBU: HILO←HILO−product.
- Addition and subtraction are modulo 2^(2W).
- The accumulate reads HILO at the write edge.

Divide:
- Restoring, one quotient bit per cycle, on magnitudes.
- Signed sign-fix: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Result: LO←quotient, HI←remainder.
- Divide by zero (signed and unsigned): LO←all ones, HI←a.
- Signed MIN/−1: LO←MIN, HI←0.

FSM states:
- IDLE: accepting ops. Goes to MUL on an accepted multiply when MUL_LATENCY>0, and to DIV on an accepted divide.
- MUL: counts MUL_LATENCY cycles, writes HILO, then returns to IDLE.
- DIV: WIDTH iterations, then FIX.
- FIX: applies the sign fix, writes HILO, then returns to IDLE.

In-flight ops are never cancelled by commit=0 or a flush. Only reset aborts them.

## Timing
Reset values:
- HILO=0, state=IDLE, busy=0, stall=0, rd_data=0 (op=NONE).
- A reset mid-operation returns the unit to IDLE, with no HILO write.

Multiply:
- Accept at edge E0; HILO written at edge E0+MUL_LATENCY.
- busy is high from after E0 until that same edge.

Divide:
- Accept at E0; iterations run at E0+1..E0+WIDTH; FIX; HILO written at edge E0+WIDTH+1.
- busy is high for WIDTH+1 cycles after E0.

Interlock:
- stall and busy fall at the HILO write edge.
- A stalled MFLO/MFHI therefore reads the new value in the next cycle.
- A stalled HILO op is accepted in that cycle if commit is high.

Operand capture and busy behaviour:
- Operands are captured at accept; later changes to a and b have no effect.
- Non-HILO ops (op=NONE) see stall=0 even when busy=1.

## Structure
Shared package muldiv_pkg contains:
- The muldiv_op_t enum.
- The state enum {IDLE, MUL, DIV, FIX}.
- A helper function is_hilo_access(op).

Sub-module div_iter contains:
- The WIDTH-bit restoring divider core, with a start input, a done output, and magnitude-in/quotient-remainder-out.
- muldiv_hilo owns the sign handling and the FIX state.

## Test plan
- Reset, then MTHI a=0x12345678 and MTLO b=0x9ABCDEF0, then MFHI/MFLO -> rd_data 0x12345678, then 0x9ABCDEF0.
- MULT a=0xFFFFFFFF, b=2, MUL_LATENCY=2 -> busy for 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=1, LO=0xFFFFFFFE.
- DIV a=−7, b=2, then MFLO issued next cycle -> stall held for 33 cycles; then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU with b=0, a=5 -> LO=0xFFFFFFFF, HI=5. DIV a=0x80000000, b=−1 -> LO=0x80000000, HI=0.
- With HILO=0x0000_0001_0000_0000: MADD a=b=0x10000 -> HILO=0x0000_0002_0000_0000; then MSUBU a=b=1 -> HILO=0x0000_0001_FFFF_FFFF.
- Divide in flight with op=NONE -> stall=0. Divide in flight with commit=0 -> completes normally. Reset at iteration 10 -> busy=0 and HILO=0 next cycle.
